mfb_meta_join: RTL

MFB_META_JOIN -- requirements
Module: mfb_meta_join

---
 rtl/mfb_meta_join_pkg.sv | 35 +++
 rtl/mfb_meta_join_meta_fifo.sv | 51 +++++
 rtl/mfb_meta_join.sv | 95 +++++++++
 3 files changed

// File: rtl/mfb_meta_join_pkg.sv
// rtl/mfb_meta_join_pkg.sv - shared MFB constants and derived-width helpers for mfb_meta_join
package mfb_meta_join_pkg;

  // MFB layout constants; this block is single-region
  localparam int MFB_REGIONS         = 1;
  localparam int MFB_REGION_SIZE_DEF = 8;
  localparam int MFB_BLOCK_SIZE_DEF  = 8;
  localparam int MFB_ITEM_WIDTH_DEF  = 8;
  localparam int MFB_META_WIDTH_DEF  = 32;
  localparam int MFB_FIFO_DEPTH_DEF  = 16;

  // log2 that never returns zero, so single-entry fields still get one bit
  function automatic int log2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Derived widths of the MFB word and its position fields
  function automatic int data_w(input int region_size, input int block_size, input int item_width);
    return MFB_REGIONS * region_size * block_size * item_width;
  endfunction

  function automatic int sof_pos_w(input int region_size);
    return log2w(region_size);
  endfunction

  function automatic int eof_pos_w(input int region_size, input int block_size);
    return log2w(region_size * block_size);
  endfunction

  // Pointers carry one extra bit so full and empty are distinguishable without wrap logic
  function automatic int ptr_w(input int depth);
    return log2w(depth) + 1;
  endfunction

endpackage

// File: rtl/mfb_meta_join_meta_fifo.sv
// rtl/mfb_meta_join_meta_fifo.sv - register-based metadata FIFO with full, empty and occupancy
module mfb_meta_join_meta_fifo
  import mfb_meta_join_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = log2w(DEPTH),
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    status
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Occupancy comes straight from registered pointers, so a push is never visible in its own cycle
  assign status  = wr_ptr - rd_ptr;
  assign full    = (status == PW'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage array, no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mfb_meta_join.sv
// rtl/mfb_meta_join.sv - attaches per-frame metadata to the SOF word of an MFB stream
module mfb_meta_join
  import mfb_meta_join_pkg::*;
#(
  parameter int REGION_SIZE = MFB_REGION_SIZE_DEF,
  parameter int BLOCK_SIZE  = MFB_BLOCK_SIZE_DEF,
  parameter int ITEM_WIDTH  = MFB_ITEM_WIDTH_DEF,
  parameter int META_WIDTH  = MFB_META_WIDTH_DEF,
  parameter int FIFO_DEPTH  = MFB_FIFO_DEPTH_DEF,
  localparam int DW  = data_w(REGION_SIZE, BLOCK_SIZE, ITEM_WIDTH),
  localparam int SPW = sof_pos_w(REGION_SIZE),
  localparam int EPW = eof_pos_w(REGION_SIZE, BLOCK_SIZE),
  localparam int PW  = ptr_w(FIFO_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DW-1:0]         RX_DATA,
  input  logic [SPW-1:0]        RX_SOF_POS,
  input  logic [EPW-1:0]        RX_EOF_POS,
  input  logic                  RX_SOF,
  input  logic                  RX_EOF,
  input  logic                  RX_SRC_RDY,
  output logic                  RX_DST_RDY,
  input  logic [META_WIDTH-1:0] RX_META_DATA,
  input  logic                  RX_META_VLD,
  input  logic                  RX_META_SRC_RDY,
  output logic                  RX_META_DST_RDY,
  output logic [DW-1:0]         TX_DATA,
  output logic [SPW-1:0]        TX_SOF_POS,
  output logic [EPW-1:0]        TX_EOF_POS,
  output logic                  TX_SOF,
  output logic                  TX_EOF,
  output logic                  TX_SRC_RDY,
  input  logic                  TX_DST_RDY,
  output logic [META_WIDTH-1:0] TX_META,
  output logic [PW-1:0]         FIFO_STATUS
);

  logic                  en;
  logic                  rx_xfer;
  logic                  meta_push;
  logic                  meta_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [META_WIDTH-1:0] fifo_head;

  // Output stage advances when its word is taken or it holds nothing
  assign en         = TX_DST_RDY | ~TX_SRC_RDY;
  // A SOF word (including EOF+SOF words) waits until its metadata is queued
  assign RX_DST_RDY = en & (~RX_SOF | ~fifo_empty);
  assign rx_xfer    = RX_SRC_RDY & RX_DST_RDY;
  assign meta_pop   = rx_xfer & RX_SOF;

  // Held low through reset; a same-cycle pop does not open a slot
  assign RX_META_DST_RDY = RESET_N & ~fifo_full;
  // Invalid metadata words are accepted and dropped
  assign meta_push       = RX_META_SRC_RDY & RX_META_VLD & RX_META_DST_RDY;

  mfb_meta_join_meta_fifo #(
    .WIDTH (META_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) meta_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (meta_push),
    .push_data (RX_META_DATA),
    .pop       (meta_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .status    (FIFO_STATUS)
  );

  // Output valid: set on an accepted word, cleared when the stage drains without refill
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      TX_SRC_RDY <= 1'b0;
    end else if (en) begin
      TX_SRC_RDY <= rx_xfer;
    end
  end

  // Output payload and metadata, not reset; metadata only changes on a SOF word
  always_ff @(posedge CLK) begin
    if (rx_xfer) begin
      TX_DATA    <= RX_DATA;
      TX_SOF_POS <= RX_SOF_POS;
      TX_EOF_POS <= RX_EOF_POS;
      TX_SOF     <= RX_SOF;
      TX_EOF     <= RX_EOF;
    end
    if (meta_pop) TX_META <= fifo_head;
  end

endmodule
